de2i_150_qsys_display_mode_out: RTL and testbench

//  Avalon-MM slave output PIO. The host writes the display-mode word, and the block drives it to the display pipeline.

---
 rtl/de2i_150_qsys_display_mode_out_pkg.sv | 37 +++
 rtl/de2i_150_qsys_display_apply_fsm.sv | 84 ++++++++
 rtl/de2i_150_qsys_display_mode_out.sv | 162 ++++++++++++++++
 tb/tb_de2i_150_qsys_display_mode_out.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/de2i_150_qsys_display_mode_out_pkg.sv
// Shared definitions for the display-mode output PIO.
// Contents:
//   - register word offsets
//   - CTRL and STATUS bit positions
//   - apply FSM state encoding
//   - helper that sizes the timeout counter
package de2i_150_qsys_display_mode_out_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_ACTIVE   = 3'd1;
  localparam logic [2:0] ADDR_CTRL     = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  localparam int CTRL_IMMEDIATE_BIT = 0;
  localparam int CTRL_IRQ_EN_BIT    = 1;

  localparam int STATUS_PENDING_BIT = 0;
  localparam int STATUS_APPLIED_BIT = 1;
  localparam int STATUS_TIMEOUT_BIT = 2;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } apply_state_e;

  // Counter must hold 0..TIMEOUT; a disabled timeout still keeps a 1-bit counter.
  function automatic int cnt_width(input int timeout);
    if (timeout > 0) begin
      return $clog2(timeout + 1);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/de2i_150_qsys_display_apply_fsm.sv
// Apply sequencer for the display-mode shadow register.
// Responsibilities:
//   - detects rising edges of frame_sync
//   - tracks whether a staged value is pending
//   - counts cycles spent pending, for the optional forced apply
//   - generates the post-apply strobe
// Ports:
//   clk, reset_n    clock and asynchronous active-low reset
//   frame_sync      frame boundary, synchronous to clk
//   shadow_wr       the shadow register is written this cycle
//   immediate       CTRL.IMMEDIATE
//   pending         a staged value is waiting to be applied
//   apply           the shadow is copied to the output at this edge (combinational)
//   timeout_apply   this apply was caused by the timeout alone (combinational)
//   update_strobe   registered pulse, high in the cycle after an apply
module de2i_150_qsys_display_apply_fsm
  import de2i_150_qsys_display_mode_out_pkg::*;
#(
  parameter int TIMEOUT = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic frame_sync,
  input  logic shadow_wr,
  input  logic immediate,
  output logic pending,
  output logic apply,
  output logic timeout_apply,
  output logic update_strobe
);

  localparam int              CNT_W    = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  apply_state_e     state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             sync_q_r;
  logic             strobe_r;
  logic             sync_edge_s;
  logic             timeout_hit_s;
  logic             apply_s;
  logic             timeout_apply_s;

  // Decode the apply condition from the current state, the sync edge and the counter.
  always_comb begin
    sync_edge_s     = frame_sync & ~sync_q_r;
    timeout_hit_s   = (TIMEOUT != 0) && (cnt_r == CNT_LAST);
    apply_s         = (state_r == ST_PENDING) && (sync_edge_s || immediate || timeout_hit_s);
    timeout_apply_s = apply_s & ~sync_edge_s & ~immediate;
  end

  // Update the state, the pending-cycle counter, the edge-detect history and the strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      sync_q_r <= 1'b1;
      strobe_r <= 1'b0;
    end else begin
      sync_q_r <= frame_sync;
      strobe_r <= apply_s;
      if (apply_s) begin
        // A write landing on the apply edge re-arms the FSM for the new value.
        state_r <= shadow_wr ? ST_PENDING : ST_IDLE;
        cnt_r   <= {CNT_W{1'b0}};
      end else if (shadow_wr && (state_r == ST_IDLE)) begin
        state_r <= ST_PENDING;
        cnt_r   <= {CNT_W{1'b0}};
      end else if (state_r == ST_PENDING) begin
        state_r <= state_r;
        cnt_r   <= cnt_r + CNT_W'(1);
      end else begin
        state_r <= state_r;
        cnt_r   <= cnt_r;
      end
    end
  end

  assign pending       = (state_r == ST_PENDING);
  assign apply         = apply_s;
  assign timeout_apply = timeout_apply_s;
  assign update_strobe = strobe_r;

endmodule

// File: rtl/de2i_150_qsys_display_mode_out.sv
// Avalon-MM output PIO for the display mode.
// Host writes are staged in a shadow register. The staged value reaches
// out_port on a frame_sync rising edge, on a timeout, or immediately when
// CTRL.IMMEDIATE is set, so the display pipeline never sees a mid-frame
// mode change.
// Ports:
//   clk, reset_n                                   clock and asynchronous active-low reset
//   address, chipselect, write_n, writedata        Avalon-MM slave write side
//   readdata                                       registered read data, 1-cycle latency
//   frame_sync                                     frame boundary from display timing
//   out_port                                       active display mode
//   update_strobe                                  pulse in the cycle after an apply
//   irq                                            STATUS.APPLIED & CTRL.IRQ_EN
module de2i_150_qsys_display_mode_out
  import de2i_150_qsys_display_mode_out_pkg::*;
#(
  parameter int          WIDTH       = 4,
  parameter int unsigned RESET_VALUE = 32'd0,
  parameter int          TIMEOUT     = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] out_port,
  output logic             update_strobe,
  output logic             irq
);

  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

  logic             write_s;
  logic             shadow_wr_s;
  logic [WIDTH-1:0] wd_s;
  logic [WIDTH-1:0] shadow_nxt_s;
  logic [1:0]       ctrl_nxt_s;
  logic             applied_nxt_s;
  logic             timeout_nxt_s;
  logic [31:0]      rdata_s;
  logic             pending_s;
  logic             apply_s;
  logic             timeout_apply_s;
  logic             status_w1c_s;
  logic             unused_ok_s;

  logic [WIDTH-1:0] shadow_r;
  logic [WIDTH-1:0] out_port_r;
  logic [1:0]       ctrl_r;
  logic             applied_r;
  logic             timeout_r;
  logic             irq_r;
  logic [31:0]      readdata_r;

  assign write_s     = chipselect & ~write_n;
  assign wd_s        = writedata[WIDTH-1:0];
  assign unused_ok_s = ^writedata;

  // Decode host writes into the next shadow, CTRL and sticky STATUS values.
  always_comb begin
    shadow_nxt_s = shadow_r;
    shadow_wr_s  = 1'b0;
    if (write_s) begin
      case (address)
        ADDR_DATA: begin
          shadow_nxt_s = wd_s;
          shadow_wr_s  = 1'b1;
        end
        ADDR_OUTSET: begin
          shadow_nxt_s = shadow_r | wd_s;
          shadow_wr_s  = 1'b1;
        end
        ADDR_OUTCLEAR: begin
          shadow_nxt_s = shadow_r & ~wd_s;
          shadow_wr_s  = 1'b1;
        end
        default: begin
          shadow_nxt_s = shadow_r;
          shadow_wr_s  = 1'b0;
        end
      endcase
    end else begin
      shadow_nxt_s = shadow_r;
      shadow_wr_s  = 1'b0;
    end

    ctrl_nxt_s   = (write_s && (address == ADDR_CTRL)) ? writedata[1:0] : ctrl_r;
    status_w1c_s = write_s && (address == ADDR_STATUS);

    // A set on the same edge as a write-1-to-clear takes priority.
    if (apply_s) begin
      applied_nxt_s = 1'b1;
    end else if (status_w1c_s && writedata[STATUS_APPLIED_BIT]) begin
      applied_nxt_s = 1'b0;
    end else begin
      applied_nxt_s = applied_r;
    end

    if (timeout_apply_s) begin
      timeout_nxt_s = 1'b1;
    end else if (status_w1c_s && writedata[STATUS_TIMEOUT_BIT]) begin
      timeout_nxt_s = 1'b0;
    end else begin
      timeout_nxt_s = timeout_r;
    end
  end

  // Read mux; the write-only and reserved words read as zero.
  always_comb begin
    case (address)
      ADDR_DATA:   rdata_s = 32'(shadow_r);
      ADDR_ACTIVE: rdata_s = 32'(out_port_r);
      ADDR_CTRL:   rdata_s = 32'(ctrl_r);
      ADDR_STATUS: rdata_s = 32'({timeout_r, applied_r, pending_s});
      default:     rdata_s = 32'd0;
    endcase
  end

  // Register the host-visible state, the active output and the read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_r   <= RST_VAL;
      out_port_r <= RST_VAL;
      ctrl_r     <= 2'b00;
      applied_r  <= 1'b0;
      timeout_r  <= 1'b0;
      irq_r      <= 1'b0;
      readdata_r <= 32'd0;
    end else begin
      shadow_r   <= shadow_nxt_s;
      // The apply captures the shadow as it stood before any same-edge write.
      out_port_r <= apply_s ? shadow_r : out_port_r;
      ctrl_r     <= ctrl_nxt_s;
      applied_r  <= applied_nxt_s;
      timeout_r  <= timeout_nxt_s;
      irq_r      <= applied_nxt_s & ctrl_nxt_s[CTRL_IRQ_EN_BIT];
      readdata_r <= rdata_s;
    end
  end

  de2i_150_qsys_display_apply_fsm #(
    .TIMEOUT (TIMEOUT)
  ) u_apply_fsm (
    .clk           (clk),
    .reset_n       (reset_n),
    .frame_sync    (frame_sync),
    .shadow_wr     (shadow_wr_s),
    .immediate     (ctrl_r[CTRL_IMMEDIATE_BIT]),
    .pending       (pending_s),
    .apply         (apply_s),
    .timeout_apply (timeout_apply_s),
    .update_strobe (update_strobe)
  );

  assign out_port = out_port_r;
  assign readdata = readdata_r;
  assign irq      = irq_r;

endmodule

// File: tb/tb_de2i_150_qsys_display_mode_out.sv
module tb_de2i_150_qsys_display_mode_out;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        frame_sync;
  logic [3:0]  out_port;
  logic        update_strobe;
  logic        irq;

  int n_checks;
  int n_pass;

  de2i_150_qsys_display_mode_out #(
    .WIDTH       (4),
    .RESET_VALUE (32'd0),
    .TIMEOUT     (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .address       (address),
    .chipselect    (chipselect),
    .write_n       (write_n),
    .writedata     (writedata),
    .readdata      (readdata),
    .frame_sync    (frame_sync),
    .out_port      (out_port),
    .update_strobe (update_strobe),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  logic [31:0] r;

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    reset_n    = 1'b0;
    frame_sync = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = 32'd0;

    // 1. reset with frame_sync held high
    #1;
    check("rst_readdata", readdata, 32'd0);
    check("rst_out_port", {28'd0, out_port}, 32'd0);
    check("rst_strobe", {31'd0, update_strobe}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    tick();
    check("rel_out_port", {28'd0, out_port}, 32'd0);
    check("rel_strobe", {31'd0, update_strobe}, 32'd0);
    rd(3'd3, r);
    check("rel_status", r, 32'd0);
    frame_sync = 1'b0;
    tick();

    // 2. staged DATA write applied on frame_sync edge
    wr(3'd0, 32'h5);
    rd(3'd3, r);
    check("t2_status_pending", r, 32'h1);
    for (int i = 0; i < 9; i++) tick();
    check("t2_hold_out_port", {28'd0, out_port}, 32'h0);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    check("t2_out_port", {28'd0, out_port}, 32'h5);
    check("t2_strobe_hi", {31'd0, update_strobe}, 32'd1);
    tick();
    check("t2_strobe_lo", {31'd0, update_strobe}, 32'd0);
    rd(3'd3, r);
    check("t2_status_applied", r, 32'h2);
    check("t2_irq", {31'd0, irq}, 32'd0);

    // 3. OUTSET / OUTCLEAR merge into shadow
    wr(3'd4, 32'h8);
    wr(3'd5, 32'h1);
    rd(3'd0, r);
    check("t3_data", r, 32'hC);
    rd(3'd1, r);
    check("t3_active", r, 32'h5);
    rd(3'd4, r);
    check("t3_outset_reads0", r, 32'h0);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    check("t3_out_port", {28'd0, out_port}, 32'hC);
    tick();

    // 4. IMMEDIATE mode and irq
    wr(3'd2, 32'h1);
    wr(3'd0, 32'h3);
    check("t4_before", {28'd0, out_port}, 32'hC);
    tick();
    check("t4_out_port", {28'd0, out_port}, 32'h3);
    check("t4_irq_off", {31'd0, irq}, 32'd0);
    wr(3'd2, 32'h3);
    check("t4_irq_on", {31'd0, irq}, 32'd1);
    wr(3'd3, 32'h2);
    check("t4_irq_cleared", {31'd0, irq}, 32'd0);
    wr(3'd2, 32'h0);
    rd(3'd3, r);
    check("t4_status", r, 32'h0);

    // 5. timeout apply after 16 pending cycles
    wr(3'd0, 32'hA);
    for (int i = 0; i < 15; i++) tick();
    check("t5_not_yet", {28'd0, out_port}, 32'h3);
    tick();
    check("t5_out_port", {28'd0, out_port}, 32'hA);
    check("t5_strobe", {31'd0, update_strobe}, 32'd1);
    rd(3'd3, r);
    check("t5_status", r, 32'h6);
    wr(3'd3, 32'h6);
    rd(3'd3, r);
    check("t5_w1c", r, 32'h0);

    // 6. write coinciding with a sync edge
    wr(3'd0, 32'h2);
    frame_sync = 1'b1;
    wr(3'd0, 32'h7);
    frame_sync = 1'b0;
    check("t6_out_port_old", {28'd0, out_port}, 32'h2);
    rd(3'd3, r);
    check("t6_status", r, 32'h3);
    rd(3'd0, r);
    check("t6_shadow", r, 32'h7);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    check("t6_out_port_new", {28'd0, out_port}, 32'h7);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
